// File: rtl/decoder_pipe_pkg.sv
// decoder_pipe_pkg: decode mode encoding and legal code-width bounds shared by the decoder_pipe slice.
package decoder_pipe_pkg;

    typedef enum logic [1:0] {
        DEC_MODE_ONEHOT = 2'b00,
        DEC_MODE_LE     = 2'b01,
        DEC_MODE_GT     = 2'b10,
        DEC_MODE_INV    = 2'b11
    } dec_mode_e;

    localparam int IN_W_MIN = 1;
    localparam int IN_W_MAX = 8;

    function automatic bit in_w_legal(input int w);
        return (w >= IN_W_MIN) && (w <= IN_W_MAX);
    endfunction

endpackage

// File: rtl/decoder_vec_gen.sv
// decoder_vec_gen: combinational code -> one-hot / mask vector builder.
module decoder_vec_gen
    import decoder_pipe_pkg::*;
#(
    parameter  int IN_W  = 5,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic [IN_W-1:0]  code,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [OUT_W-1:0] vec
);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        localparam logic [IN_W-1:0] idx = IN_W'(i);
        assign vec[i] = en & (mode == DEC_MODE_ONEHOT ? idx == code :
                              mode == DEC_MODE_LE     ? idx <= code :
                              mode == DEC_MODE_GT     ? idx >  code :
                                                        idx != code);
    end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered IN_W -> 2^IN_W decoder with valid/ready handshake.
// Define DECODE_SKID_EN to add a one-entry skid so in_ready no longer depends on out_ready.
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter  int IN_W  = 5,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [1:0]       in_mode,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    output logic [IN_W-1:0]  out_code
);

    if (!in_w_legal(IN_W)) begin : g_bad_in_w
        $error("decoder_pipe: IN_W must be in 1..8");
    end

    logic [IN_W-1:0]  gen_code;
    logic [1:0]       gen_mode;
    logic             gen_en;
    logic [OUT_W-1:0] gen_vec;
    logic             accept;

    assign accept = in_valid & in_ready;

    decoder_vec_gen #(.IN_W(IN_W)) u_vec_gen (
        .code (gen_code),
        .mode (gen_mode),
        .en   (gen_en),
        .vec  (gen_vec)
    );

`ifdef DECODE_SKID_EN
    logic            skid_valid;
    logic [IN_W-1:0] skid_code;
    logic [1:0]      skid_mode;
    logic            skid_en;

    assign in_ready = ~skid_valid;
    // The skid holds only the request; its vector is rebuilt when it moves up.
    assign gen_code = skid_valid ? skid_code : in_code;
    assign gen_mode = skid_valid ? skid_mode : in_mode;
    assign gen_en   = skid_valid ? skid_en   : in_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_code   <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_vec    <= gen_vec;
                out_code   <= gen_code;
                skid_valid <= 1'b0;
            end
        end else if (accept && out_valid && !out_ready) begin
            skid_valid <= 1'b1;
            skid_code  <= in_code;
            skid_mode  <= in_mode;
            skid_en    <= in_en;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_vec   <= gen_vec;
            out_code  <= gen_code;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;
    assign gen_code = in_code;
    assign gen_mode = in_mode;
    assign gen_en   = in_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_code  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_vec   <= gen_vec;
            out_code  <= gen_code;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: table-driven vectors plus scoreboard for decoder_pipe (IN_W=5 and IN_W=6).
module tb_decoder_pipe;

    typedef struct {
        logic [4:0]  code;
        logic [1:0]  mode;
        logic        en;
        logic [31:0] vec;
    } vec_t;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] vec;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_code = '0;
    logic [1:0]  in_mode = '0;
    logic        in_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_vec;
    logic [4:0]  out_code;

    logic        v6_valid = 1'b0;
    logic        v6_ready;
    logic [5:0]  v6_code = '0;
    logic [1:0]  v6_mode = '0;
    logic        v6_en = 1'b0;
    logic        o6_valid;
    logic        o6_ready = 1'b0;
    logic [63:0] o6_vec;
    logic [5:0]  o6_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stream_on = 0;
    int stream_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    sb_t sb[$];
    sb_t sb_e;
    vec_t tbl[13];

    always #5 clk = ~clk;

    decoder_pipe #(.IN_W(5)) u5 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_mode(in_mode), .in_en(in_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_code(out_code)
    );

    decoder_pipe #(.IN_W(6)) u6 (
        .clk(clk), .reset(rst), .in_valid(v6_valid), .in_ready(v6_ready),
        .in_code(v6_code), .in_mode(v6_mode), .in_en(v6_en),
        .out_valid(o6_valid), .out_ready(o6_ready), .out_vec(o6_vec), .out_code(o6_code)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference vector built arithmetically, independent of the per-bit RTL form.
    function automatic logic [31:0] model(input logic [4:0] c, input logic [1:0] m, input logic e);
        logic [31:0] oh;
        logic [31:0] le;
        oh = 32'd1 << c;
        le = (c == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (c + 1)) - 32'd1);
        if (!e) return 32'h0;
        case (m)
            2'b00:   return oh;
            2'b01:   return le;
            2'b10:   return ~le;
            default: return ~oh;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [4:0] c, input logic [1:0] m, input logic e, input logic [31:0] ev);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_code  = c;
        in_mode  = m;
        in_en    = e;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{c, ev});
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_code  = 'x;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: code %0d never accepted, in_ready %b want 1", c, in_ready);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got code %0d vec %h want no output", out_code, out_vec);
            end else begin
                sb_e = sb.pop_front();
                check("sb_vec", {32'h0, out_vec}, {32'h0, sb_e.vec});
                check("sb_code", {59'h0, out_code}, {59'h0, sb_e.code});
            end
            if (stream_on != 0) begin
                if (stream_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                stream_cnt++;
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{5'd7,  2'b00, 1'b1, 32'h0000_0080};
        tbl[1]  = '{5'd3,  2'b01, 1'b1, 32'h0000_000F};
        tbl[2]  = '{5'd31, 2'b01, 1'b1, 32'hFFFF_FFFF};
        tbl[3]  = '{5'd3,  2'b10, 1'b1, 32'hFFFF_FFF0};
        tbl[4]  = '{5'd0,  2'b11, 1'b1, 32'hFFFF_FFFE};
        tbl[5]  = '{5'd31, 2'b10, 1'b1, 32'h0000_0000};
        tbl[6]  = '{5'd31, 2'b11, 1'b1, 32'h7FFF_FFFF};
        tbl[7]  = '{5'd0,  2'b00, 1'b1, 32'h0000_0001};
        tbl[8]  = '{5'd0,  2'b01, 1'b1, 32'h0000_0001};
        tbl[9]  = '{5'd9,  2'b00, 1'b0, 32'h0000_0000};
        tbl[10] = '{5'd9,  2'b01, 1'b0, 32'h0000_0000};
        tbl[11] = '{5'd9,  2'b10, 1'b0, 32'h0000_0000};
        tbl[12] = '{5'd9,  2'b11, 1'b0, 32'h0000_0000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'd0);
        check("rst_out_vec", {32'h0, out_vec}, 64'd0);
        check("rst_out_code", {59'h0, out_code}, 64'd0);
        check("rst_in_ready", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int t = 0; t < 13; t++) begin
            send(tbl[t].code, tbl[t].mode, tbl[t].en, tbl[t].vec);
            repeat (2) @(posedge clk);
            #1;
        end
        drain();

        // Stall: result 4 held while request 12 waits (or sits in skid).
        send(5'd4, 2'b00, 1'b1, 32'h0000_0010);
        out_ready = 1'b0;
        fork
            send(5'd12, 2'b00, 1'b1, 32'h0000_1000);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_vec", {32'h0, out_vec}, 64'h10);
                    check("stall_code", {59'h0, out_code}, 64'd4);
                    check("stall_valid", {63'h0, out_valid}, 64'd1);
                    if (k > 0) check("stall_in_ready", {63'h0, in_ready}, 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        stream_on = 1;
        for (int c = 0; c < 32; c++) send(5'(c), 2'b00, 1'b1, model(5'(c), 2'b00, 1'b1));
        drain();
        stream_on = 0;
        check("stream_count", 64'(stream_cnt), 64'd32);
        check("stream_span", 64'(last_cyc - first_cyc), 64'd31);

        for (int k = 0; k < 6; k++) begin
            logic [4:0] c;
            logic [1:0] m;
            c = 5'($urandom_range(0, 31));
            m = 2'($urandom_range(0, 3));
            send(c, m, 1'b1, model(c, m, 1'b1));
        end
        drain();

        // Reset while stalled discards the held entry.
        send(5'd20, 2'b00, 1'b1, 32'h0010_0000);
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {63'h0, out_valid}, 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {63'h0, out_valid}, 64'd0);
        check("post_rst_vec", {32'h0, out_vec}, 64'd0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {63'h0, out_valid}, 64'd0);

        // IN_W=6 instance.
        @(posedge clk);
        #1;
        o6_ready = 1'b1;
        v6_valid = 1'b1;
        v6_code  = 6'd63;
        v6_mode  = 2'b00;
        v6_en    = 1'b1;
        @(negedge clk);
        check("w6_in_ready", {63'h0, v6_ready}, 64'd1);
        @(posedge clk);
        #1;
        v6_valid = 1'b0;
        o6_ready = 1'b0;
        @(negedge clk);
        check("w6_valid", {63'h0, o6_valid}, 64'd1);
        check("w6_vec", o6_vec, 64'h8000_0000_0000_0000);
        check("w6_code", {58'h0, o6_code}, 64'd63);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("w6_rst_valid", {63'h0, o6_valid}, 64'd0);
        check("w6_rst_vec", o6_vec, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
